peak_capture: RTL and testbench

- Pulse-height capture stage that sits directly downstream of the trapezoidal shaping filter.
- Consumes the shaped filter stream one sample per clk and detects pulses crossing a programmable threshold.
- For each pulse, captures the flat-top maximum and its timestamp, then presents one event record over a valid/ready handshake to the histogram/readout stage.
- Flags pile-up (over-long pulses) and counts events lost while the output is stalled.

---
 rtl/peak_capture.sv | 156 +++++++++++++++
 tb/tb_peak_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/peak_capture.sv
// Pulse-height capture: tracks the flat-top maximum of each above-threshold pulse
// and presents one {amp, time, pileup} record per pulse over valid/ready.
module peak_capture #(
  parameter int DATA_W  = 17,
  parameter int TS_W    = 32,
  parameter int MAX_LEN = 32,
  parameter int HOLDOFF = 13,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] filt_data,
  input  logic [DATA_W-1:0] threshold,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_amp,
  output logic [TS_W-1:0]   evt_time,
  output logic              evt_pileup,
  output logic              busy,
  output logic [CNT_W-1:0]  lost_cnt
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int HOLD_W = $clog2(HOLDOFF + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_REPORT,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [TS_W-1:0]     ts_q;
  logic                prev_above_q;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [TS_W-1:0]     max_ts_q, max_ts_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   amp_q, amp_d;
  logic [TS_W-1:0]     time_q, time_d;
  logic                pile_q, pile_d;
  logic [CNT_W-1:0]    lost_q, lost_d;

  logic                above;
  logic                rising;
  logic                greater;
  logic [LEN_W-1:0]    len_inc;
  logic [DATA_W-1:0]   cur_max;
  logic [TS_W-1:0]     cur_ts;

  assign above   = $signed(filt_data) > $signed(threshold);
  assign rising  = above && !prev_above_q;
  assign greater = $signed(filt_data) > $signed(max_q);
  assign len_inc = len_q + LEN_W'(1);

  // Running max including the current sample; strict compare keeps the earliest tie.
  assign cur_max = greater ? filt_data : max_q;
  assign cur_ts  = greater ? ts_q : max_ts_q;

  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    max_ts_d = max_ts_q;
    len_d    = len_q;
    hold_d   = hold_q;
    amp_d    = amp_q;
    time_d   = time_q;
    pile_d   = pile_q;
    lost_d   = lost_q;

    case (state_q)
      S_IDLE: begin
        if (above) begin
          max_d    = filt_data;
          max_ts_d = ts_q;
          len_d    = LEN_W'(1);
          state_d  = S_TRACK;
        end
      end
      S_TRACK: begin
        if (!above) begin
          amp_d   = max_q;
          time_d  = max_ts_q;
          pile_d  = 1'b0;
          state_d = S_REPORT;
        end else begin
          len_d    = len_inc;
          max_d    = cur_max;
          max_ts_d = cur_ts;
          if (len_inc == LEN_W'(MAX_LEN)) begin
            amp_d   = cur_max;
            time_d  = cur_ts;
            pile_d  = 1'b1;
            state_d = S_REPORT;
          end
        end
      end
      S_REPORT: begin
        if (evt_ready) begin
          hold_d  = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Counter stops at HOLDOFF-1; from then on only a quiet input re-arms.
        if (hold_q < HOLD_W'(HOLDOFF - 1)) begin
          hold_d = hold_q + HOLD_W'(1);
        end else if (!above) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_REPORT || state_q == S_HOLD) && rising && (lost_q != '1)) begin
      lost_d = lost_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ts_q         <= '0;
      prev_above_q <= 1'b0;
      max_q        <= '0;
      max_ts_q     <= '0;
      len_q        <= '0;
      hold_q       <= '0;
      amp_q        <= '0;
      time_q       <= '0;
      pile_q       <= 1'b0;
      lost_q       <= '0;
    end else begin
      state_q      <= state_d;
      ts_q         <= ts_q + TS_W'(1);
      prev_above_q <= above;
      max_q        <= max_d;
      max_ts_q     <= max_ts_d;
      len_q        <= len_d;
      hold_q       <= hold_d;
      amp_q        <= amp_d;
      time_q       <= time_d;
      pile_q       <= pile_d;
      lost_q       <= lost_d;
    end
  end

  assign evt_valid  = (state_q == S_REPORT);
  assign busy       = (state_q != S_IDLE);
  assign evt_amp    = amp_q;
  assign evt_time   = time_q;
  assign evt_pileup = pile_q;
  assign lost_cnt   = lost_q;

endmodule

// File: tb/tb_peak_capture.sv
// Directed bench for peak_capture: baseline pulse, ties/threshold edge, pile-up,
// backpressure with lost events, negative levels and reset during a pending record.
module tb_peak_capture;

  localparam int DATA_W = 17;
  localparam int TS_W   = 32;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] filt_data;
  logic [DATA_W-1:0] threshold;
  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_amp;
  logic [TS_W-1:0]   evt_time;
  logic              evt_pileup;
  logic              busy;
  logic [CNT_W-1:0]  lost_cnt;

  int unsigned total;
  int unsigned bad;
  int unsigned tb_ts;
  int unsigned t_peak;
  logic [DATA_W-1:0] amp_exp;

  peak_capture #(
    .DATA_W (DATA_W),
    .TS_W   (TS_W),
    .MAX_LEN(32),
    .HOLDOFF(13),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .filt_data (filt_data),
    .threshold (threshold),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_amp   (evt_amp),
    .evt_time  (evt_time),
    .evt_pileup(evt_pileup),
    .busy      (busy),
    .lost_cnt  (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic [DATA_W-1:0] d);
    filt_data = d;
    @(posedge clk);
    #1;
    tb_ts++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input logic [DATA_W-1:0] low);
    evt_ready = 1'b1;
    tick(low);
    evt_ready = 1'b0;
    repeat (13) tick(low);
  endtask

  initial begin
    total = 0;
    bad = 0;
    tb_ts = 0;
    reset = 1'b0;
    filt_data = '0;
    threshold = 17'd100;
    evt_ready = 1'b0;

    // Reset state
    tick(0);
    tick(0);
    reset = 1'b1;
    tb_ts = 0;
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_amp", 64'(evt_amp), 64'd0);
    chk("rst_time", 64'(evt_time), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lost", 64'(lost_cnt), 64'd0);

    // Trapezoid baseline starting at ts=10
    repeat (10) tick(0);
    tick(0);
    tick(150);
    chk("t1_busy", 64'(busy), 64'd1);
    tick(400);
    tick(400);
    tick(400);
    tick(200);
    chk("t1_early_valid", 64'(evt_valid), 64'd0);
    tick(50);
    chk("t1_valid_ts", 64'(tb_ts), 64'd17);
    chk("t1_valid", 64'(evt_valid), 64'd1);
    chk("t1_amp", 64'(evt_amp), 64'd400);
    chk("t1_time", 64'(evt_time), 64'd12);
    chk("t1_pileup", 64'(evt_pileup), 64'd0);
    evt_ready = 1'b1;
    tick(0);
    evt_ready = 1'b0;
    chk("t1_valid_clr", 64'(evt_valid), 64'd0);
    repeat (12) tick(0);
    chk("t1_hold_busy", 64'(busy), 64'd1);
    tick(0);
    chk("t1_rearm", 64'(busy), 64'd0);

    // Equality is not a crossing; ties keep the earliest sample
    tick(100);
    tick(100);
    chk("t2_eq_busy", 64'(busy), 64'd0);
    chk("t2_eq_valid", 64'(evt_valid), 64'd0);
    tick(101);
    t_peak = tb_ts;
    tick(300);
    tick(300);
    tick(0);
    chk("t2_valid", 64'(evt_valid), 64'd1);
    chk("t2_amp", 64'(evt_amp), 64'd300);
    chk("t2_time", 64'(evt_time), 64'(t_peak));
    drain(0);
    chk("t2_idle", 64'(busy), 64'd0);

    // Pile-up: long pulse reported at MAX_LEN, tail must not retrigger
    threshold = 17'd50;
    t_peak = tb_ts;
    repeat (31) tick(500);
    chk("t3_len31_valid", 64'(evt_valid), 64'd0);
    tick(500);
    chk("t3_valid", 64'(evt_valid), 64'd1);
    chk("t3_pileup", 64'(evt_pileup), 64'd1);
    chk("t3_amp", 64'(evt_amp), 64'd500);
    chk("t3_time", 64'(evt_time), 64'(t_peak));
    evt_ready = 1'b1;
    tick(500);
    evt_ready = 1'b0;
    repeat (17) tick(500);
    chk("t3_tail_busy", 64'(busy), 64'd1);
    chk("t3_tail_valid", 64'(evt_valid), 64'd0);
    tick(50);
    chk("t3_rearm", 64'(busy), 64'd0);
    chk("t3_lost", 64'(lost_cnt), 64'd0);

    // Backpressure: two pulses during a 20-cycle stall are lost
    threshold = 17'd100;
    tick(0);
    tick(300);
    t_peak = tb_ts - 1;
    tick(0);
    chk("t4_valid", 64'(evt_valid), 64'd1);
    tick(0); tick(0); tick(200); tick(0); tick(0);
    tick(250); tick(250); tick(0);
    repeat (12) tick(0);
    chk("t4_stall_valid", 64'(evt_valid), 64'd1);
    chk("t4_stall_amp", 64'(evt_amp), 64'd300);
    chk("t4_stall_time", 64'(evt_time), 64'(t_peak));
    chk("t4_stall_pileup", 64'(evt_pileup), 64'd0);
    chk("t4_lost", 64'(lost_cnt), 64'd2);
    evt_ready = 1'b1;
    tick(0);
    chk("t4_hs_clr", 64'(evt_valid), 64'd0);
    tick(0);
    tick(0);
    chk("t4_single_hs", 64'(evt_valid), 64'd0);
    evt_ready = 1'b0;
    repeat (11) tick(0);
    chk("t4_idle", 64'(busy), 64'd0);

    // Negative threshold and baseline
    threshold = -17'sd200;
    tick(-17'sd500);
    tick(-17'sd500);
    tick(-17'sd300);
    t_peak = tb_ts;
    tick(-17'sd150);
    tick(-17'sd180);
    tick(-17'sd500);
    amp_exp = -17'sd150;
    chk("t5_valid", 64'(evt_valid), 64'd1);
    chk("t5_amp", 64'(evt_amp), 64'(amp_exp));
    chk("t5_time", 64'(evt_time), 64'(t_peak));
    chk("t5_lost", 64'(lost_cnt), 64'd2);
    drain(-17'sd500);
    chk("t5_idle", 64'(busy), 64'd0);

    // Reset while a record is pending
    threshold = 17'd100;
    tick(0);
    tick(300);
    tick(0);
    chk("t6_pending", 64'(evt_valid), 64'd1);
    reset = 1'b0;
    tick(0);
    reset = 1'b1;
    tb_ts = 0;
    chk("t6_valid", 64'(evt_valid), 64'd0);
    chk("t6_amp", 64'(evt_amp), 64'd0);
    chk("t6_time", 64'(evt_time), 64'd0);
    chk("t6_pileup", 64'(evt_pileup), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_lost", 64'(lost_cnt), 64'd0);
    tick(0);
    tick(0);
    tick(300);
    tick(0);
    chk("t6_new_valid", 64'(evt_valid), 64'd1);
    chk("t6_ts_restart", 64'(evt_time), 64'd2);
    evt_ready = 1'b1;
    tick(0);
    evt_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
